cluster_wake_req_buffer: RTL and testbench
==========================================

# cluster_wake_req_buffer

Request front-end for the cluster slave port, sitting directly upstream of the cluster clock-gate controller on the ungated cluster clock. It forwards external requests into the cluster and drives the clock gate's incoming-request input. When the cluster is isolated, it accepts and buffers one request, wakes the clock gate, and waits for isolation to drop plus a guard interval. It then replays the request into the cluster.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, write data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- WAKE_GUARD, 2, cycles to wait after isolation deasserts before replay (0 allowed)

Ports:
- clk_i  in  1  ungated cluster clock
- rstn_i  in  1  asynchronous active-low reset
- isolate_cluster_i  in  1  high = cluster clock-gated or entering gating; no request may reach the cluster
- incoming_req_o  out  1  to clock-gate controller; high prevents or aborts gating
- busy_o  out  1  high while a buffered request is pending (state != IDLE)
- slv_req_i  in  1  external request
- slv_add_i  in  ADDR_WIDTH  address
- slv_wen_i  in  1  write-enable, active low
- slv_wdata_i  in  DATA_WIDTH  write data
- slv_be_i  in  BE_WIDTH  byte enables
- slv_gnt_o  out  1  grant to external master
- mst_req_o  out  1  request into cluster
- mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o  out  as slave side  forwarded payload
- mst_gnt_i  in  1  grant from cluster

## Operation
- FSM states: IDLE, WAKE, GUARD, FWD. Payload register: add, wen, wdata, be. Guard counter is $clog2(WAKE_GUARD+1) bits wide, minimum 1.
- IDLE, isolate_cluster_i=0: combinational pass-through.
  - mst_* = slv_*, mst_req_o = slv_req_i, slv_gnt_o = mst_gnt_i.
  - incoming_req_o = slv_req_i.
- IDLE, isolate_cluster_i=1, slv_req_i=1:
  - mst_req_o=0.
  - slv_gnt_o=1 in the same cycle; payload captured on that clock edge.
  - incoming_req_o=1 combinationally.
  - Next state WAKE.
- IDLE, isolate=1, slv_req_i=0: all outputs 0.
- WAKE:
  - incoming_req_o=1, slv_gnt_o=0, mst_req_o=0.
  - When isolate_cluster_i=0: go to GUARD with counter loaded to WAKE_GUARD, or go straight to FWD if WAKE_GUARD=0.
- GUARD:
  - incoming_req_o=1, slv_gnt_o=0, mst_req_o=0.
  - Counter decrements each cycle; at counter==1, go to FWD.
  - isolate_cluster_i=1 during GUARD returns the FSM to WAKE.
- FWD:
  - mst_req_o=1 with the buffered payload; incoming_req_o=1; slv_gnt_o=0.
  - mst_req_o and payload stay stable until mst_gnt_i. On mst_gnt_i, go to IDLE.
  - isolate_cluster_i=1 in FWD (recovery case only) drops mst_req_o and returns to WAKE.
- busy_o = (state != IDLE). It is intended to be ORed into the cluster internal-busy term.
- The buffer depth is one. A new slave request is never granted while state != IDLE.
- The response path is not handled here. The cluster stays ungated during the response because busy/req hold the gate open.

## Timing
- Reset values: state IDLE, payload registers 0, counter 0. All outputs are 0 with slv_req_i=0.
- Pass-through latency is 0 cycles, fully combinational.
- Buffered path:
  - Capture and grant in cycle 0. WAKE from cycle 1.
  - If isolate_cluster_i is first sampled low in cycle k, GUARD occupies cycles k+1..k+WAKE_GUARD.
  - mst_req_o first asserts in cycle k+1+WAKE_GUARD. For WAKE_GUARD=0, it asserts in k+1.
- incoming_req_o is continuously high from the capture cycle through the mst_gnt_i cycle inclusive.
- A new slave grant is possible at the earliest in the cycle after the FWD grant.
- Reset asserted mid-operation discards the buffered request immediately and drops all outputs asynchronously.

## Test plan
- Pass-through: isolate=0, slv_req=1 with add=0x1000_0040, cluster grants after 2 cycles -> mst_req mirrors slv_req, slv_gnt is high in the same cycle as mst_gnt, busy_o stays 0.
- Wake replay: isolate=1, write add=0x1000_0080, wdata=0xDEADBEEF, be=0xF; isolate drops 5 cycles later; WAKE_GUARD=2 -> slv_gnt in cycle 0, incoming_req high from cycle 0, mst_req high 3 cycles after isolate is sampled low with the exact payload.
- Back-pressure: in FWD, mst_gnt held low 4 cycles -> mst_req and payload are stable; a second slv_req is not granted until the cycle after mst_gnt.
- Isolation re-asserts in GUARD: isolate pulses high for 1 cycle at GUARD cycle 1 -> FSM returns to WAKE, counter reloads, no mst_req before the full guard completes.
- WAKE_GUARD=0 build: isolate drops in cycle k -> mst_req asserts in cycle k+1.
- Reset in WAKE: rstn_i low with a pending request -> busy_o, incoming_req_o and mst_req_o go 0 asynchronously; after release the FSM is IDLE and the request is not replayed.

Source files
------------

// File: rtl/cluster_wake_req_buffer.sv
// Request front-end for the cluster slave port: pass-through when awake,
// one-deep buffer plus wake/guard/replay sequence while the cluster is isolated.
module cluster_wake_req_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int WAKE_GUARD = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  isolate_cluster_i,
    output logic                  incoming_req_o,
    output logic                  busy_o,
    input  logic                  slv_req_i,
    input  logic [ADDR_WIDTH-1:0] slv_add_i,
    input  logic                  slv_wen_i,
    input  logic [DATA_WIDTH-1:0] slv_wdata_i,
    input  logic [BE_WIDTH-1:0]   slv_be_i,
    output logic                  slv_gnt_o,
    output logic                  mst_req_o,
    output logic [ADDR_WIDTH-1:0] mst_add_o,
    output logic                  mst_wen_o,
    output logic [DATA_WIDTH-1:0] mst_wdata_o,
    output logic [BE_WIDTH-1:0]   mst_be_o,
    input  logic                  mst_gnt_i
);

    localparam int CW = (WAKE_GUARD > 0) ? $clog2(WAKE_GUARD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        GUARD,
        FWD
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] add_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            add_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                add_q   <= slv_add_i;
                wen_q   <= slv_wen_i;
                wdata_q <= slv_wdata_i;
                be_q    <= slv_be_i;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        capture        = 1'b0;
        incoming_req_o = 1'b0;
        slv_gnt_o      = 1'b0;
        mst_req_o      = 1'b0;
        mst_add_o      = add_q;
        mst_wen_o      = wen_q;
        mst_wdata_o    = wdata_q;
        mst_be_o       = be_q;
        unique case (state_q)
            IDLE: begin
                mst_add_o   = '0;
                mst_wen_o   = 1'b0;
                mst_wdata_o = '0;
                mst_be_o    = '0;
                if (!isolate_cluster_i) begin
                    mst_req_o      = slv_req_i;
                    mst_add_o      = slv_add_i;
                    mst_wen_o      = slv_wen_i;
                    mst_wdata_o    = slv_wdata_i;
                    mst_be_o       = slv_be_i;
                    slv_gnt_o      = mst_gnt_i;
                    incoming_req_o = slv_req_i;
                end else if (slv_req_i) begin
                    // Accept now; the cluster sees it only after wake-up
                    slv_gnt_o      = 1'b1;
                    incoming_req_o = 1'b1;
                    capture        = 1'b1;
                    state_d        = WAKE;
                end
            end
            WAKE: begin
                incoming_req_o = 1'b1;
                if (!isolate_cluster_i) begin
                    if (WAKE_GUARD == 0) begin
                        state_d = FWD;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = CW'(WAKE_GUARD);
                    end
                end
            end
            GUARD: begin
                incoming_req_o = 1'b1;
                if (isolate_cluster_i) begin
                    state_d = WAKE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = FWD;
                end
            end
            FWD: begin
                incoming_req_o = 1'b1;
                if (isolate_cluster_i) begin
                    state_d = WAKE;
                end else begin
                    mst_req_o = 1'b1;
                    if (mst_gnt_i) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_cluster_wake_req_buffer.sv
// Bench for cluster_wake_req_buffer: vector table for idle behaviour, scoreboard
// on the cluster-side handshake, hand sequences for wake/guard/reset corners.
module tb_cluster_wake_req_buffer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        iso, req, wen, gnt;
    logic [31:0] add, wdata;
    logic [3:0]  be;

    logic        inc, busy, sgnt, mreq, mwen;
    logic [31:0] madd, mwdata;
    logic [3:0]  mbe;
    logic        z_inc, z_busy, z_sgnt, z_mreq, z_mwen;
    logic [31:0] z_madd, z_mwdata;
    logic [3:0]  z_mbe;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] add;
        logic [31:0] wdata;
        logic        wen;
        logic [3:0]  be;
    } txn_t;
    txn_t sb[$];

    typedef struct {
        logic        iso, req, wen, gnt;
        logic [31:0] add, wdata;
        logic [3:0]  be;
        logic        e_mreq, e_sgnt, e_inc, e_busy;
        logic [31:0] e_add;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    cluster_wake_req_buffer #(.WAKE_GUARD(2)) dut (
        .clk_i(clk), .rstn_i(rstn), .isolate_cluster_i(iso),
        .incoming_req_o(inc), .busy_o(busy),
        .slv_req_i(req), .slv_add_i(add), .slv_wen_i(wen),
        .slv_wdata_i(wdata), .slv_be_i(be), .slv_gnt_o(sgnt),
        .mst_req_o(mreq), .mst_add_o(madd), .mst_wen_o(mwen),
        .mst_wdata_o(mwdata), .mst_be_o(mbe), .mst_gnt_i(gnt)
    );

    cluster_wake_req_buffer #(.WAKE_GUARD(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .isolate_cluster_i(iso),
        .incoming_req_o(z_inc), .busy_o(z_busy),
        .slv_req_i(req), .slv_add_i(add), .slv_wen_i(wen),
        .slv_wdata_i(wdata), .slv_be_i(be), .slv_gnt_o(z_sgnt),
        .mst_req_o(z_mreq), .mst_add_o(z_madd), .mst_wen_o(z_mwen),
        .mst_wdata_o(z_mwdata), .mst_be_o(z_mbe), .mst_gnt_i(gnt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cluster-side handshake monitor
    always @(negedge clk) begin
        if (rstn && mon_en && mreq && gnt) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(madd), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                txn_t t;
                t = sb.pop_front();
                chk("sb_add", 64'(madd), 64'(t.add));
                chk("sb_wdata", 64'(mwdata), 64'(t.wdata));
                chk("sb_wen", 64'(mwen), 64'(t.wen));
                chk("sb_be", 64'(mbe), 64'(t.be));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        iso = 0; req = 0; wen = 0; gnt = 0;
        add = '0; wdata = '0; be = '0;
    endtask

    task automatic do_reset();
        mon_en = 0;
        idle_in();
        rstn = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        cyc();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] b);
        txn_t t;
        t.add = a; t.wdata = d; t.wen = w; t.be = b;
        sb.push_back(t);
    endtask

    initial begin
        vecs[0] = '{0, 1, 1, 0, 32'h1000_0040, 32'h0, 4'hF, 1, 0, 1, 0, 32'h1000_0040};
        vecs[1] = '{0, 1, 0, 1, 32'h1000_0044, 32'h55, 4'h1, 1, 1, 1, 0, 32'h1000_0044};
        vecs[2] = '{0, 0, 1, 1, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 0, 0, 32'h0000_0010};
        vecs[3] = '{1, 0, 1, 1, 32'h2000_0000, 32'h77, 4'hF, 0, 0, 0, 0, 32'h0};
        vecs[4] = '{1, 1, 0, 0, 32'h3000_0000, 32'h99, 4'hF, 0, 1, 1, 0, 32'h0};
        vecs[5] = '{0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0};

        do_reset();
        @(negedge clk);
        chk("rst_mreq", 64'(mreq), 64'd0);
        chk("rst_sgnt", 64'(sgnt), 64'd0);
        chk("rst_inc", 64'(inc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mwdata", 64'(mwdata), 64'd0);

        // Combinational idle behaviour; req is cleared before each edge
        foreach (vecs[i]) begin
            @(negedge clk);
            iso = vecs[i].iso; req = vecs[i].req; wen = vecs[i].wen;
            gnt = vecs[i].gnt; add = vecs[i].add; wdata = vecs[i].wdata;
            be = vecs[i].be;
            #1;
            chk($sformatf("v%0d_mreq", i), 64'(mreq), 64'(vecs[i].e_mreq));
            chk($sformatf("v%0d_sgnt", i), 64'(sgnt), 64'(vecs[i].e_sgnt));
            chk($sformatf("v%0d_inc", i), 64'(inc), 64'(vecs[i].e_inc));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d_madd", i), 64'(madd), 64'(vecs[i].e_add));
            idle_in();
        end

        // Pass-through, cluster grants in the third cycle
        do_reset();
        mon_en = 1;
        req = 1; add = 32'h1000_0040; wen = 1; be = 4'hF;
        for (int c = 0; c < 3; c++) begin
            gnt = (c == 2);
            if (c == 2) push(32'h1000_0040, 32'h0, 1'b1, 4'hF);
            @(negedge clk);
            chk("pt_mreq", 64'(mreq), 64'd1);
            chk("pt_sgnt", 64'(sgnt), 64'(c == 2));
            chk("pt_busy", 64'(busy), 64'd0);
            cyc();
        end
        idle_in();

        // Wake replay plus back-pressure in FWD
        do_reset();
        mon_en = 1;
        iso = 1; req = 1; wen = 0; add = 32'h1000_0080;
        wdata = 32'hDEAD_BEEF; be = 4'hF;
        push(32'h1000_0080, 32'hDEAD_BEEF, 1'b0, 4'hF);
        @(negedge clk);
        chk("wk0_sgnt", 64'(sgnt), 64'd1);
        chk("wk0_inc", 64'(inc), 64'd1);
        chk("wk0_mreq", 64'(mreq), 64'd0);
        cyc();
        req = 0; add = '0; wdata = '0; be = '0; wen = 1;
        for (int c = 1; c <= 7; c++) begin
            iso = (c < 5);
            @(negedge clk);
            chk($sformatf("wk%0d_mreq", c), 64'(mreq), 64'd0);
            chk($sformatf("wk%0d_inc", c), 64'(inc), 64'd1);
            chk($sformatf("wk%0d_sgnt", c), 64'(sgnt), 64'd0);
            chk($sformatf("wk%0d_busy", c), 64'(busy), 64'd1);
            cyc();
        end
        for (int c = 8; c <= 12; c++) begin
            gnt = (c == 12);
            if (c >= 9) begin
                req = 1; add = 32'h2000_0004; wdata = 32'h1234_5678;
                be = 4'h3; wen = 1;
            end
            @(negedge clk);
            chk($sformatf("bp%0d_mreq", c), 64'(mreq), 64'd1);
            chk($sformatf("bp%0d_madd", c), 64'(madd), 64'h1000_0080);
            chk($sformatf("bp%0d_mwdata", c), 64'(mwdata), 64'hDEAD_BEEF);
            chk($sformatf("bp%0d_mwen", c), 64'(mwen), 64'd0);
            chk($sformatf("bp%0d_sgnt", c), 64'(sgnt), 64'd0);
            chk($sformatf("bp%0d_inc", c), 64'(inc), 64'd1);
            cyc();
        end
        push(32'h2000_0004, 32'h1234_5678, 1'b1, 4'h3);
        @(negedge clk);
        chk("bp13_busy", 64'(busy), 64'd0);
        chk("bp13_sgnt", 64'(sgnt), 64'd1);
        chk("bp13_madd", 64'(madd), 64'h2000_0004);
        cyc();
        idle_in();

        // Isolation pulse in the first GUARD cycle restarts the guard
        do_reset();
        mon_en = 1;
        iso = 1; req = 1; wen = 1; add = 32'h1000_00C0;
        wdata = 32'hA5A5_0001; be = 4'hC;
        push(32'h1000_00C0, 32'hA5A5_0001, 1'b1, 4'hC);
        @(negedge clk);
        chk("gd0_sgnt", 64'(sgnt), 64'd1);
        cyc();
        req = 0;
        for (int c = 1; c <= 5; c++) begin
            iso = (c == 2);
            @(negedge clk);
            chk($sformatf("gd%0d_mreq", c), 64'(mreq), 64'd0);
            chk($sformatf("gd%0d_inc", c), 64'(inc), 64'd1);
            cyc();
        end
        iso = 0; gnt = 1;
        @(negedge clk);
        chk("gd6_mreq", 64'(mreq), 64'd1);
        chk("gd6_madd", 64'(madd), 64'h1000_00C0);
        cyc();
        gnt = 0;
        @(negedge clk);
        chk("gd7_busy", 64'(busy), 64'd0);
        cyc();

        // Zero-guard build replays one cycle after isolate drops
        do_reset();
        iso = 1; req = 1; wen = 0; add = 32'h1000_0100;
        wdata = 32'h0BAD_F00D; be = 4'h5;
        @(negedge clk);
        chk("z0_sgnt", 64'(z_sgnt), 64'd1);
        cyc();
        req = 0; add = '0; wdata = '0;
        @(negedge clk);
        chk("z1_mreq", 64'(z_mreq), 64'd0);
        chk("z1_busy", 64'(z_busy), 64'd1);
        cyc();
        iso = 0;
        @(negedge clk);
        chk("z2_mreq", 64'(z_mreq), 64'd0);
        cyc();
        gnt = 1;
        @(negedge clk);
        chk("z3_mreq", 64'(z_mreq), 64'd1);
        chk("z3_madd", 64'(z_madd), 64'h1000_0100);
        chk("z3_mwdata", 64'(z_mwdata), 64'h0BAD_F00D);
        cyc();
        gnt = 0;
        @(negedge clk);
        chk("z4_busy", 64'(z_busy), 64'd0);
        cyc();

        // Asynchronous reset while waiting in WAKE
        do_reset();
        iso = 1; req = 1; add = 32'h1000_0200; wdata = 32'h1; be = 4'hF;
        cyc();
        req = 0;
        @(negedge clk);
        chk("rw_busy_pre", 64'(busy), 64'd1);
        #1 rstn = 0;
        #1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_inc", 64'(inc), 64'd0);
        chk("rw_mreq", 64'(mreq), 64'd0);
        chk("rw_z_busy", 64'(z_busy), 64'd0);
        @(negedge clk);
        rstn = 1;
        cyc();
        iso = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rw%0d_mreq", c), 64'(mreq | z_mreq), 64'd0);
            chk($sformatf("rw%0d_busy", c), 64'(busy | z_busy), 64'd0);
            cyc();
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
